microwave_ctrl: RTL and testbench
=================================

Name: microwave_ctrl

Overview:
- Sequencing controller for the microwave countdown timer (BCD mins/sec_tens/sec_ones with serial digit load).
- Accepts keypad digits, start, stop/clear and door status.
- Shifts digits into the timer, enables and pauses the countdown, drives the magnetron enable, and raises a completion beep when the timer reaches zero.
- Sits between the keypad/door front end and the timer datapath.

Parameters:
- BEEP_CYCLES, 6: number of clk cycles done_beep stays high after countdown completes.
- MAX_DIGITS, 3: maximum digits accepted per entry; further digits are ignored.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- key_valid  in  1  one-cycle strobe; key_digit is valid.
- key_digit  in  4  BCD digit 0-9 from the keypad.
- start  in  1  one-cycle start request.
- stop  in  1  one-cycle stop/clear request.
- door_closed  in  1  level; 1 = door shut.
- timer_zero  in  1  timer reports 0:00.
- timer_loadn  out  1  active-low digit shift strobe to the timer.
- timer_clrn  out  1  active-low clear to the timer.
- timer_en  out  1  countdown enable to the timer.
- timer_data  out  4  digit presented with timer_loadn.
- mag_on  out  1  magnetron enable.
- done_beep  out  1  completion indicator.
- busy  out  1  high in COOKING or PAUSED.

Behaviour:
- All outputs are registered and change one cycle after the causing input.
- Reset values while clr is high: state=IDLE, timer_loadn=1, timer_clrn=0 (timer is cleared alongside the controller), timer_en=0, timer_data=0, mag_on=0, done_beep=0, busy=0, digit count=0.
- Reset release: timer_clrn returns to 1 on the first cycle after clr falls.
- clr mid-operation aborts any state immediately, including during beep or cooking.
- States: IDLE, SETTING, COOKING, PAUSED, DONE.
- Priority when inputs coincide: stop > door open > timer_zero > start > key_valid.
- IDLE:
  - key_valid with key_digit ≤ 9: timer_loadn=0 and timer_data=key_digit for exactly one cycle; count=1; go to SETTING.
  - Digit > 9: ignored.
  - stop: one-cycle timer_clrn=0.
- SETTING:
  - Each valid digit shifts into the timer as in IDLE while count < MAX_DIGITS; further digits are ignored (count saturates at MAX_DIGITS).
  - stop: timer_clrn=0 for one cycle, count=0, go to IDLE.
  - start with door_closed=1 and timer_zero=0: go to COOKING.
  - start with door open or timer_zero=1: ignored.
- COOKING:
  - timer_en=1, mag_on=1, busy=1.
  - Door open or stop: go to PAUSED (timer_en=0, mag_on=0).
  - timer_zero: timer_en=0, mag_on=0, go to DONE.
  - Keys are ignored.
- PAUSED:
  - busy=1; the timer holds its value.
  - start with door_closed: return to COOKING.
  - stop: timer_clrn=0 for one cycle, go to IDLE.
  - Keys are ignored.
- DONE:
  - done_beep=1 for BEEP_CYCLES cycles, then go to IDLE with count=0.
  - stop, door open, or key_valid ends the beep early and goes to IDLE (the key is not loaded).
- timer_loadn is never low in the same cycle as timer_clrn=0 or timer_en=1.

Optional Feature:
- Macro: MICROWAVE_QUICK_START_EN.
- When defined:
  - start in IDLE with door_closed enters state QLOAD.
  - QLOAD shifts digits 0, 3, 0 on three consecutive cycles (timer_loadn=0 each cycle), i.e. 0:30, then enters COOKING.
  - stop or door open during QLOAD: timer_clrn=0 for one cycle, then go to IDLE.
- When undefined:
  - start in IDLE is ignored.
  - QLOAD does not exist.

Decomposition:
- Package microwave_pkg holds:
  - the state enum;
  - DIGIT_W=4;
  - KEY_MAX=9;
  - the quick-start digit constants (0, 3, 0).
- One natural sub-module: microwave_beep_cnt, a loadable down-counter asserting done_beep for BEEP_CYCLES cycles with an early-abort input.

Test Plan:
- Entry and cook:
  - Stimulus: keys 1, 3, 0 on separate cycles, door closed, then start.
  - Required response: three single-cycle timer_loadn pulses with timer_data 1, 3, 0; timer_en=1 and mag_on=1 one cycle after start.
- Door interrupt:
  - Stimulus: door opens mid-cook, then closes, then start.
  - Required response: timer_en=0 and mag_on=0 the next cycle, state PAUSED, busy=1; timer_en returns to 1 one cycle after start.
- Completion:
  - Stimulus: timer_zero asserted while COOKING.
  - Required response: timer_en=0 next cycle; done_beep high exactly 6 cycles; then IDLE.
- Limits:
  - Stimulus: 5 valid keys, then key_digit=12.
  - Required response: only 3 timer_loadn pulses; no pulse for 12.
- Stop and start with door open:
  - Stimulus: stop in SETTING; separately, start with door open in SETTING.
  - Required response: stop gives a one-cycle timer_clrn=0 and IDLE; start with door open leaves timer_en=0.
- Quick start (MICROWAVE_QUICK_START_EN defined):
  - Stimulus: start in IDLE with door closed.
  - Required response: data 0, 3, 0 loaded on 3 consecutive cycles, then COOKING.
- Quick start (macro undefined):
  - Stimulus: start in IDLE with door closed.
  - Required response: no output change.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave sequencing controller.
// The QLOAD state and quick-start digits are used only when
// MICROWAVE_QUICK_START_EN is defined.
package microwave_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] KEY_MAX = 4'd9;

    // Quick-start preset 0:30, shifted most-significant digit first
    localparam logic [DIGIT_W-1:0] QS_DIGIT0 = 4'd0;
    localparam logic [DIGIT_W-1:0] QS_DIGIT1 = 4'd3;
    localparam logic [DIGIT_W-1:0] QS_DIGIT2 = 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        SETTING,
        COOKING,
        PAUSED,
        DONE
`ifdef MICROWAVE_QUICK_START_EN
        ,
        QLOAD
`endif
    } state_e;

    // Quick-start digit for shift position idx (0..2)
    function automatic logic [DIGIT_W-1:0] qs_digit(input logic [1:0] idx);
        case (idx)
            2'd0:    return QS_DIGIT0;
            2'd1:    return QS_DIGIT1;
            default: return QS_DIGIT2;
        endcase
    endfunction

endpackage

// File: rtl/microwave_beep_cnt.sv
// Completion-beep timer: loadable down-counter that holds o_beep high for
// BEEP_CYCLES cycles after i_load, with an early abort.
module microwave_beep_cnt #(
    parameter int unsigned BEEP_CYCLES = 6
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_abort,
    output logic o_beep,
    output logic o_last
);

    localparam int unsigned CNT_W = $clog2(BEEP_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_beep;

    // Next count: load wins over abort, otherwise count down to zero
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = CNT_W'(BEEP_CYCLES);
        end else if (i_abort) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    // Count register and registered beep output
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt  <= '0;
            r_beep <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_beep <= (w_cnt_nxt != '0);
        end
    end

    assign o_beep = r_beep;
    // Final beep cycle: the controller leaves DONE on this edge
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave sequencing controller: keypad digit entry into the BCD timer,
// cook/pause/stop control, magnetron enable and completion beep.
// Define MICROWAVE_QUICK_START_EN to enable start-from-IDLE quick start (0:30).
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned BEEP_CYCLES = 6,
    parameter int unsigned MAX_DIGITS  = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               start,
    input  logic               stop,
    input  logic               door_closed,
    input  logic               timer_zero,
    output logic               timer_loadn,
    output logic               timer_clrn,
    output logic               timer_en,
    output logic [DIGIT_W-1:0] timer_data,
    output logic               mag_on,
    output logic               done_beep,
    output logic               busy
);

    // Count also indexes the three quick-start digits, so keep at least 2 bits
    localparam int unsigned CNT_W =
        ($clog2(MAX_DIGITS + 1) < 2) ? 2 : $clog2(MAX_DIGITS + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_timer_loadn;
    logic               r_timer_clrn;
    logic               r_timer_en;
    logic [DIGIT_W-1:0] r_timer_data;
    logic               r_mag_on;
    logic               r_busy;

    logic               w_loadn_nxt;
    logic               w_clrn_nxt;
    logic [DIGIT_W-1:0] w_data_nxt;
    logic               w_key_ok;
    logic               w_beep_load;
    logic               w_beep_abort;
    logic               w_beep_last;

    assign w_key_ok = key_valid && (key_digit <= KEY_MAX);

    // Next state and next registered outputs, resolved in priority order
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_loadn_nxt  = 1'b1;
        w_clrn_nxt   = 1'b1;
        w_data_nxt   = r_timer_data;
        w_beep_abort = 1'b0;

        case (r_state)
            IDLE: begin
                if (stop) begin
                    w_clrn_nxt = 1'b0;
                end
`ifdef MICROWAVE_QUICK_START_EN
                else if (start && door_closed) begin
                    w_state_nxt = QLOAD;
                    w_loadn_nxt = 1'b0;
                    w_data_nxt  = qs_digit(2'd0);
                    w_count_nxt = CNT_W'(1);
                end
`endif
                else if (w_key_ok) begin
                    w_state_nxt = SETTING;
                    w_loadn_nxt = 1'b0;
                    w_data_nxt  = key_digit;
                    w_count_nxt = CNT_W'(1);
                end
            end

            SETTING: begin
                if (stop) begin
                    w_clrn_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (start && door_closed && !timer_zero) begin
                    w_state_nxt = COOKING;
                end else if (w_key_ok && (r_count < CNT_W'(MAX_DIGITS))) begin
                    w_loadn_nxt = 1'b0;
                    w_data_nxt  = key_digit;
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end

            COOKING: begin
                if (stop || !door_closed) begin
                    w_state_nxt = PAUSED;
                end else if (timer_zero) begin
                    w_state_nxt = DONE;
                end
            end

            PAUSED: begin
                if (stop) begin
                    w_clrn_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (start && door_closed) begin
                    w_state_nxt = COOKING;
                end
            end

            DONE: begin
                if (stop || !door_closed || key_valid) begin
                    w_state_nxt  = IDLE;
                    w_beep_abort = 1'b1;
                end else if (w_beep_last) begin
                    w_state_nxt = IDLE;
                end
            end

`ifdef MICROWAVE_QUICK_START_EN
            // First quick-start digit is shifted on entry; count tracks the rest
            QLOAD: begin
                if (stop || !door_closed) begin
                    w_clrn_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (r_count == CNT_W'(3)) begin
                    w_state_nxt = COOKING;
                end else begin
                    w_loadn_nxt = 1'b0;
                    w_data_nxt  = qs_digit(r_count[1:0]);
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end
`endif

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_state_nxt == IDLE) begin
            w_count_nxt = '0;
        end
    end

    assign w_beep_load = (r_state == COOKING) && (w_state_nxt == DONE);

    // State, digit count and all controller outputs are registered here
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_timer_loadn <= 1'b1;
            r_timer_clrn  <= 1'b0;
            r_timer_en    <= 1'b0;
            r_timer_data  <= '0;
            r_mag_on      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_timer_loadn <= w_loadn_nxt;
            r_timer_clrn  <= w_clrn_nxt;
            r_timer_en    <= (w_state_nxt == COOKING);
            r_timer_data  <= w_data_nxt;
            r_mag_on      <= (w_state_nxt == COOKING);
            r_busy        <= (w_state_nxt == COOKING) || (w_state_nxt == PAUSED);
        end
    end

    microwave_beep_cnt #(
        .BEEP_CYCLES(BEEP_CYCLES)
    ) u_beep_cnt (
        .i_clk  (clk),
        .i_clr  (clr),
        .i_load (w_beep_load),
        .i_abort(w_beep_abort),
        .o_beep (done_beep),
        .o_last (w_beep_last)
    );

    assign timer_loadn = r_timer_loadn;
    assign timer_clrn  = r_timer_clrn;
    assign timer_en    = r_timer_en;
    assign timer_data  = r_timer_data;
    assign mag_on      = r_mag_on;
    assign busy        = r_busy;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Testbench for microwave_ctrl: directed scenarios followed by random
// stimulus, all compared cycle by cycle against a behavioural model.
// Honours MICROWAVE_QUICK_START_EN in the same way as the design.
module tb_microwave_ctrl;

    localparam int BEEP = 6;
    localparam int MAXD = 3;

    logic       clk = 1'b0;
    logic       clr;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       timer_zero;
    logic       timer_loadn;
    logic       timer_clrn;
    logic       timer_en;
    logic [3:0] timer_data;
    logic       mag_on;
    logic       done_beep;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int load_pulses;
    int beep_hi;

    typedef enum {M_IDLE, M_SET, M_COOK, M_PAUSE, M_DONE, M_QLOAD} mode_t;
    mode_t      m_mode;
    int         m_digits;
    int         m_beep_left;
    int         m_qstep;
    logic       e_loadn, e_clrn, e_en, e_mag, e_beep, e_busy;
    logic [3:0] e_data;

    microwave_ctrl #(
        .BEEP_CYCLES(BEEP),
        .MAX_DIGITS (MAXD)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .start      (start),
        .stop       (stop),
        .door_closed(door_closed),
        .timer_zero (timer_zero),
        .timer_loadn(timer_loadn),
        .timer_clrn (timer_clrn),
        .timer_en   (timer_en),
        .timer_data (timer_data),
        .mag_on     (mag_on),
        .done_beep  (done_beep),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Model: apply the inputs just sampled at a rising edge
    task automatic model_step();
        e_loadn = 1'b1;
        e_clrn  = 1'b1;
        if (clr) begin
            m_mode      = M_IDLE;
            m_digits    = 0;
            m_beep_left = 0;
            e_clrn      = 1'b0;
            e_data      = 4'd0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (stop) e_clrn = 1'b0;
`ifdef MICROWAVE_QUICK_START_EN
                    else if (start && door_closed) begin
                        m_mode = M_QLOAD; e_loadn = 1'b0; e_data = 4'd0; m_qstep = 1;
                    end
`endif
                    else if (key_valid && key_digit <= 9) begin
                        m_mode = M_SET; e_loadn = 1'b0; e_data = key_digit; m_digits = 1;
                    end
                end
                M_SET: begin
                    if (stop) begin
                        e_clrn = 1'b0; m_mode = M_IDLE;
                    end else if (start && door_closed && !timer_zero) begin
                        m_mode = M_COOK;
                    end else if (key_valid && key_digit <= 9 && m_digits < MAXD) begin
                        e_loadn = 1'b0; e_data = key_digit; m_digits++;
                    end
                end
                M_COOK: begin
                    if (stop || !door_closed) m_mode = M_PAUSE;
                    else if (timer_zero) begin
                        m_mode = M_DONE; m_beep_left = BEEP;
                    end
                end
                M_PAUSE: begin
                    if (stop) begin
                        e_clrn = 1'b0; m_mode = M_IDLE;
                    end else if (start && door_closed) m_mode = M_COOK;
                end
                M_DONE: begin
                    if (stop || !door_closed || key_valid) m_mode = M_IDLE;
                    else begin
                        m_beep_left--;
                        if (m_beep_left == 0) m_mode = M_IDLE;
                    end
                end
                M_QLOAD: begin
                    if (stop || !door_closed) begin
                        e_clrn = 1'b0; m_mode = M_IDLE;
                    end else if (m_qstep == 3) m_mode = M_COOK;
                    else begin
                        e_loadn = 1'b0;
                        e_data  = (m_qstep == 1) ? 4'd3 : 4'd0;
                        m_qstep++;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
            if (m_mode == M_IDLE) m_digits = 0;
        end
        e_en   = (m_mode == M_COOK);
        e_mag  = (m_mode == M_COOK);
        e_busy = (m_mode == M_COOK) || (m_mode == M_PAUSE);
        e_beep = (m_mode == M_DONE);
    endtask

    // One clock: update the model at the edge, then compare every output
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        if (timer_loadn === 1'b0) load_pulses++;
        if (done_beep === 1'b1) beep_hi++;
        check({tag, ".loadn"}, 32'(timer_loadn), 32'(e_loadn));
        check({tag, ".clrn"},  32'(timer_clrn),  32'(e_clrn));
        check({tag, ".en"},    32'(timer_en),    32'(e_en));
        check({tag, ".data"},  32'(timer_data),  32'(e_data));
        check({tag, ".mag"},   32'(mag_on),      32'(e_mag));
        check({tag, ".beep"},  32'(done_beep),   32'(e_beep));
        check({tag, ".busy"},  32'(busy),        32'(e_busy));
        check({tag, ".load_excl"},
              32'(timer_loadn == 1'b0 && (timer_clrn == 1'b0 || timer_en == 1'b1)), 32'd0);
    endtask

    task automatic step(input string tag, input logic kv, input logic [3:0] kd,
                        input logic st, input logic sp);
        key_valid = kv; key_digit = kd; start = st; stop = sp;
        tick(tag);
        key_valid = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        clr = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0;
        door_closed = 1'b1; timer_zero = 1'b0;
        load_pulses = 0; beep_hi = 0;
        m_mode = M_IDLE; m_digits = 0; m_beep_left = 0; m_qstep = 0;

        #2;
        tick("reset");
        tick("reset");
        check("reset_clrn", 32'(timer_clrn), 32'd0);
        clr = 1'b0;
        tick("release");
        check("release_clrn", 32'(timer_clrn), 32'd1);

        // Entry and cook
        load_pulses = 0;
        step("key1", 1'b1, 4'd1, 1'b0, 1'b0);
        step("key3", 1'b1, 4'd3, 1'b0, 1'b0);
        step("key0", 1'b1, 4'd0, 1'b0, 1'b0);
        check("entry_pulses", 32'(load_pulses), 32'd3);
        step("start", 1'b0, 4'd0, 1'b1, 1'b0);
        check("cook_en", 32'(timer_en), 32'd1);
        tick("cooking");

        // Door interrupt
        door_closed = 1'b0;
        tick("door_open");
        check("pause_busy", 32'(busy), 32'd1);
        door_closed = 1'b1;
        tick("door_shut");
        step("resume", 1'b0, 4'd0, 1'b1, 1'b0);
        check("resume_en", 32'(timer_en), 32'd1);

        // Completion
        beep_hi = 0;
        timer_zero = 1'b1;
        tick("tzero");
        timer_zero = 1'b0;
        for (int i = 0; i < 10; i++) tick("beep");
        check("beep_len", 32'(beep_hi), 32'(BEEP));

        // Limits: five keys then an invalid digit
        load_pulses = 0;
        step("lim_k0", 1'b1, 4'd5, 1'b0, 1'b0);
        step("lim_k1", 1'b1, 4'd9, 1'b0, 1'b0);
        step("lim_k2", 1'b1, 4'd2, 1'b0, 1'b0);
        step("lim_k3", 1'b1, 4'd7, 1'b0, 1'b0);
        step("lim_k4", 1'b1, 4'd4, 1'b0, 1'b0);
        step("lim_k12", 1'b1, 4'd12, 1'b0, 1'b0);
        check("limit_pulses", 32'(load_pulses), 32'(MAXD));

        // Stop in SETTING, then start with door open
        step("stop_set", 1'b0, 4'd0, 1'b0, 1'b1);
        check("stop_clrn", 32'(timer_clrn), 32'd0);
        tick("after_stop");
        step("key2", 1'b1, 4'd2, 1'b0, 1'b0);
        door_closed = 1'b0;
        step("start_open", 1'b0, 4'd0, 1'b1, 1'b0);
        check("open_start_en", 32'(timer_en), 32'd0);
        door_closed = 1'b1;
        step("stop2", 1'b0, 4'd0, 1'b0, 1'b1);
        tick("idle");

        // Start in IDLE
        load_pulses = 0;
        step("qs_start", 1'b0, 4'd0, 1'b1, 1'b0);
        tick("qs1");
        tick("qs2");
        tick("qs3");
`ifdef MICROWAVE_QUICK_START_EN
        check("qs_pulses", 32'(load_pulses), 32'd3);
        check("qs_cook", 32'(timer_en), 32'd1);
        step("qs_stop", 1'b0, 4'd0, 1'b0, 1'b1);
        step("qs_stop2", 1'b0, 4'd0, 1'b0, 1'b1);
`else
        check("qs_pulses", 32'(load_pulses), 32'd0);
        check("qs_cook", 32'(timer_en), 32'd0);
`endif

        // Reset mid-cook
        step("mc_key", 1'b1, 4'd4, 1'b0, 1'b0);
        step("mc_start", 1'b0, 4'd0, 1'b1, 1'b0);
        clr = 1'b1;
        tick("mc_clr");
        check("mc_clr_en", 32'(timer_en), 32'd0);
        clr = 1'b0;
        tick("mc_release");

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            int r;
            clr = ($urandom_range(0, 299) == 0);
            if (door_closed) door_closed = ($urandom_range(0, 19) != 0);
            else             door_closed = ($urandom_range(0, 3) == 0);
            timer_zero = ($urandom_range(0, 11) == 0);
            r = int'($urandom_range(0, 9));
            key_digit = 4'($urandom_range(0, 12));
            key_valid = (r < 4);
            start     = (r == 4 || r == 5);
            stop      = (r == 6);
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
